// File: rtl/pc_pkg.sv
// Shared types, encodings and helpers for the fetch-address (PC) unit.
package pc_pkg;

   // D-stage branch kinds; any code above BR_BGEZALL behaves as BR_NONE.
   typedef enum logic [3:0] {
      BR_NONE    = 4'd0,
      BR_BEQ     = 4'd1,
      BR_BNE     = 4'd2,
      BR_BLEZ    = 4'd3,
      BR_BGTZ    = 4'd4,
      BR_BLTZ    = 4'd5,
      BR_BGEZ    = 4'd6,
      BR_BGEZAL  = 4'd7,
      BR_BGEZALL = 4'd8
   } brOp_e;

   // Delay-slot control: KILL lasts exactly one edge after a not-taken
   // branch-likely, while the doomed slot instruction sits in D.
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_KILL = 1'b1
   } pcState_e;

   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
   localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
   localparam logic [31:0] IMEM_SIZE_DEF  = 32'h0000_4000;
   localparam logic [31:0] PC_STEP        = 32'h0000_0004;

   // PC-relative target: word offset scaled by 4, added to the slot address.
   function automatic logic [31:0] branchTarget(input logic [31:0] pcD,
                                                input logic [15:0] imm);
      logic [31:0] offset;
      offset = {{14{imm[15]}}, imm, 2'b00};
      return pcD + PC_STEP + offset;
   endfunction

   // Region jump: keeps the top nibble of the D-stage PC.
   function automatic logic [31:0] jumpTarget(input logic [31:0] pcD,
                                              input logic [25:0] index);
      return {pcD[31:28], index, 2'b00};
   endfunction

   // Fetch address error: misaligned or outside [base, base+size).
   // The bound is formed in 33 bits so a window ending at 2^32 still works.
   function automatic logic fetchFault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
      logic [32:0] limit;
      logic        misaligned;
      logic        belowBase;
      logic        aboveTop;
      limit      = {1'b0, base} + {1'b0, size};
      misaligned = (pc[1:0] != 2'b00);
      belowBase  = ({1'b0, pc} < {1'b0, base});
      aboveTop   = ({1'b0, pc} >= limit);
      return misaligned | belowBase | aboveTop;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Pipeline-side bundle for the PC unit: D-stage control-transfer inputs,
// M-stage exception/return requests and the fetch-side results.
interface pc_unit_if;
   import pc_pkg::*;

   logic        stall_F;
   logic [31:0] PC_D;
   logic [3:0]  br_op_D;
   logic [31:0] rs_D;
   logic [31:0] rt_D;
   logic [15:0] imm_D;
   logic        j_D;
   logic [25:0] index_D;
   logic        jr_D;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;

   logic [31:0] PC_F;
   logic        taken_D;
   logic        nullify_F;
   logic        adel_F;

   // Pipeline / hazard logic side.
   modport master (
      output stall_F, PC_D, br_op_D, rs_D, rt_D, imm_D,
             j_D, index_D, jr_D, exc_req, eret_req, epc,
      input  PC_F, taken_D, nullify_F, adel_F
   );

   // PC unit side.
   modport slave (
      input  stall_F, PC_D, br_op_D, rs_D, rt_D, imm_D,
             j_D, index_D, jr_D, exc_req, eret_req, epc,
      output PC_F, taken_D, nullify_F, adel_F
   );

endinterface

// File: rtl/pc_unit_br_cmp.sv
// Branch condition evaluator: purely combinational, operands are treated
// as signed 32-bit values. Unknown branch codes never report a true condition.
module br_cmp
   import pc_pkg::*;
(
   input  logic [3:0]  brOp,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic        cond
);

   logic rsNeg_s;
   logic rsZero_s;
   logic rsEqRt_s;

   // Sign/zero/equality flags shared by all comparisons.
   always_comb begin
      rsNeg_s  = rs[31];
      rsZero_s = (rs == 32'd0);
      rsEqRt_s = (rs == rt);
   end

   // Select the condition for the requested branch kind.
   always_comb begin
      cond = 1'b0;
      case (brOp_e'(brOp))
         BR_BEQ:     cond = rsEqRt_s;
         BR_BNE:     cond = !rsEqRt_s;
         BR_BLEZ:    cond = rsNeg_s | rsZero_s;
         BR_BGTZ:    cond = !rsNeg_s & !rsZero_s;
         BR_BLTZ:    cond = rsNeg_s;
         BR_BGEZ:    cond = !rsNeg_s;
         BR_BGEZAL:  cond = !rsNeg_s;
         BR_BGEZALL: cond = !rsNeg_s;
         BR_NONE:    cond = 1'b0;
         default:    cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-address unit: holds PC_F, resolves D-stage branches and jumps,
// services exception entry / eret, and nullifies the delay slot of a
// not-taken branch-likely.
module pc_unit
   import pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
   parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
   parameter logic [31:0] IMEM_SIZE  = IMEM_SIZE_DEF,
   parameter bit          LIKELY_EN  = 1'b1
)
(
   input  logic       clk,
   input  logic       reset,
   pc_unit_if.slave   bus
);

   pcState_e    state_r;
   pcState_e    stateNext_s;
   logic        killActive_s;
   logic [3:0]  effBrOp_s;
   logic        cond_s;
   logic        isLikely_s;
   logic        taken_s;
   logic        nullify_s;
   logic [31:0] brTarget_s;
   logic [31:0] jTarget_s;
   logic [31:0] nextPc_s;
   logic [31:0] pc_r;
   logic        adel_r;

   // FSM state register; reset drops any pending KILL.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // FSM next state: exception/eret flush any kill, KILL lasts one edge.
   always_comb begin
      stateNext_s = ST_RUN;
      if (bus.exc_req || bus.eret_req) begin
         stateNext_s = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (nullify_s) begin
                  stateNext_s = ST_KILL;
               end else begin
                  stateNext_s = ST_RUN;
               end
            end
            ST_KILL: stateNext_s = ST_RUN;
            default: stateNext_s = ST_RUN;
         endcase
      end
   end

   // FSM outputs: while killing, the slot's branch code is masked to none.
   always_comb begin
      killActive_s = 1'b0;
      effBrOp_s    = bus.br_op_D;
      case (state_r)
         ST_RUN: begin
            killActive_s = 1'b0;
            effBrOp_s    = bus.br_op_D;
         end
         ST_KILL: begin
            killActive_s = 1'b1;
            effBrOp_s    = BR_NONE;
         end
         default: begin
            killActive_s = 1'b0;
            effBrOp_s    = bus.br_op_D;
         end
      endcase
   end

   br_cmp u_brCmp (
      .brOp (effBrOp_s),
      .rs   (bus.rs_D),
      .rt   (bus.rt_D),
      .cond (cond_s)
   );

   // D-stage transfer decision and branch-likely nullify request.
   always_comb begin
      taken_s    = bus.j_D | bus.jr_D | cond_s;
      isLikely_s = (effBrOp_s == BR_BGEZALL) && !killActive_s;
      if (LIKELY_EN && isLikely_s && !cond_s && !bus.stall_F
          && !bus.exc_req && !bus.eret_req) begin
         nullify_s = 1'b1;
      end else begin
         nullify_s = 1'b0;
      end
   end

   // Candidate redirect targets computed from the D-stage PC.
   always_comb begin
      brTarget_s = branchTarget(bus.PC_D, bus.imm_D);
      jTarget_s  = jumpTarget(bus.PC_D, bus.index_D);
   end

   // Next fetch address by priority; exception/eret ignore the stall.
   always_comb begin
      nextPc_s = pc_r + PC_STEP;
      if (bus.exc_req) begin
         nextPc_s = HANDLER_PC;
      end else if (bus.eret_req) begin
         nextPc_s = bus.epc;
      end else if (bus.stall_F) begin
         nextPc_s = pc_r;
      end else if (bus.j_D) begin
         nextPc_s = jTarget_s;
      end else if (cond_s) begin
         nextPc_s = brTarget_s;
      end else if (bus.jr_D) begin
         nextPc_s = bus.rs_D;
      end else begin
         nextPc_s = pc_r + PC_STEP;
      end
   end

   // PC register with its address-error flag computed alongside, so the
   // flag always describes the PC value being presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r   <= RESET_PC;
         adel_r <= fetchFault(RESET_PC, IMEM_BASE, IMEM_SIZE);
      end else begin
         pc_r   <= nextPc_s;
         adel_r <= fetchFault(nextPc_s, IMEM_BASE, IMEM_SIZE);
      end
   end

   assign bus.PC_F      = pc_r;
   assign bus.adel_F    = adel_r;
   assign bus.taken_D   = taken_s;
   assign bus.nullify_F = nullify_s;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   checkCount;
   int   errCount;

   pc_unit_if bus ();

   pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition table: branch code, rs, rt, expected taken_D.
   localparam int NV = 14;
   logic [3:0]  vOp    [NV] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4,
                                4'd5, 4'd5, 4'd6, 4'd7, 4'd7, 4'd9, 4'd15};
   logic [31:0] vRs    [NV] = '{32'd1, 32'd3, 32'd0, 32'd1, 32'hFFFF_FFFF,
                                32'd1, 32'd0, 32'h8000_0000, 32'd0, 32'd0,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0};
   logic [31:0] vRt    [NV] = '{32'd2, 32'd3, 32'd9, 32'd9, 32'd9, 32'd9,
                                32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9,
                                32'd0, 32'd0};
   logic        vTaken [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   task automatic checkVal(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      bus.stall_F  = 1'b0;
      bus.PC_D     = 32'd0;
      bus.br_op_D  = 4'd0;
      bus.rs_D     = 32'd0;
      bus.rt_D     = 32'd0;
      bus.imm_D    = 16'd0;
      bus.j_D      = 1'b0;
      bus.index_D  = 26'd0;
      bus.jr_D     = 1'b0;
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      bus.epc      = 32'd0;
   endtask

   initial begin
      checkCount = 0;
      errCount   = 0;
      clearIn();
      reset = 1'b1;
      tick();
      tick();

      // Reset state and three sequential fetches.
      checkVal("rst_pc", bus.PC_F, 32'h0000_3000);
      checkVal("rst_adel", 32'(bus.adel_F), 32'd0);
      checkVal("rst_taken", 32'(bus.taken_D), 32'd0);
      checkVal("rst_null", 32'(bus.nullify_F), 32'd0);
      reset = 1'b0;
      tick();
      checkVal("seq_1", bus.PC_F, 32'h0000_3004);
      tick();
      checkVal("seq_2", bus.PC_F, 32'h0000_3008);
      tick();
      checkVal("seq_3", bus.PC_F, 32'h0000_300C);

      // Backward beq: stalled first (hold), then released.
      bus.PC_D = 32'h0000_3004; bus.br_op_D = 4'd1;
      bus.rs_D = 32'd5; bus.rt_D = 32'd5; bus.imm_D = 16'hFFFE;
      bus.stall_F = 1'b1;
      #1;
      checkVal("beq_taken", 32'(bus.taken_D), 32'd1);
      tick();
      checkVal("beq_stall_hold", bus.PC_F, 32'h0000_300C);
      bus.stall_F = 1'b0;
      tick();
      checkVal("beq_target", bus.PC_F, 32'h0000_3000);

      // Branch-likely not taken: nullify, then one KILL cycle.
      clearIn();
      bus.PC_D = 32'h0000_3000; bus.br_op_D = 4'd8; bus.rs_D = 32'hFFFF_FFFF;
      #1;
      checkVal("bl_null", 32'(bus.nullify_F), 32'd1);
      checkVal("bl_nt_taken", 32'(bus.taken_D), 32'd0);
      tick();
      checkVal("bl_pc4", bus.PC_F, 32'h0000_3004);
      // Now in KILL: slot beq with equal operands must be ignored.
      bus.PC_D = 32'h0000_3004; bus.br_op_D = 4'd1;
      bus.rs_D = 32'd7; bus.rt_D = 32'd7; bus.imm_D = 16'hFFFE;
      #1;
      checkVal("kill_taken", 32'(bus.taken_D), 32'd0);
      checkVal("kill_null", 32'(bus.nullify_F), 32'd0);
      tick();
      checkVal("kill_pc4", bus.PC_F, 32'h0000_3008);
      // Back in RUN: same beq is honoured.
      bus.PC_D = 32'h0000_3008; bus.imm_D = 16'h0004;
      #1;
      checkVal("run_taken", 32'(bus.taken_D), 32'd1);
      tick();
      checkVal("run_target", bus.PC_F, 32'h0000_301C);
      // Branch-likely taken (rs=0).
      bus.PC_D = 32'h0000_301C; bus.br_op_D = 4'd8; bus.rs_D = 32'd0;
      bus.rt_D = 32'd0; bus.imm_D = 16'h0002;
      #1;
      checkVal("bl_t_taken", 32'(bus.taken_D), 32'd1);
      checkVal("bl_t_null", 32'(bus.nullify_F), 32'd0);
      tick();
      checkVal("bl_t_target", bus.PC_F, 32'h0000_3028);

      // Nullify suppressed by stall and by exception.
      bus.br_op_D = 4'd8; bus.rs_D = 32'hFFFF_FFFF; bus.stall_F = 1'b1;
      #1;
      checkVal("null_stall", 32'(bus.nullify_F), 32'd0);
      bus.stall_F = 1'b0; bus.exc_req = 1'b1;
      #1;
      checkVal("null_exc", 32'(bus.nullify_F), 32'd0);

      // Condition table, evaluated while stalled so PC does not move.
      clearIn();
      bus.stall_F = 1'b1;
      for (int i = 0; i < NV; i++) begin
         bus.br_op_D = vOp[i]; bus.rs_D = vRs[i]; bus.rt_D = vRt[i];
         #1;
         checkVal($sformatf("cond_%0d", i), 32'(bus.taken_D), 32'(vTaken[i]));
      end

      // Exception beats stall and jump; exc beats eret; eret alone.
      clearIn();
      bus.stall_F = 1'b1; bus.exc_req = 1'b1; bus.j_D = 1'b1;
      bus.index_D = 26'd5;
      tick();
      checkVal("exc_pc", bus.PC_F, 32'h0000_4180);
      checkVal("exc_adel", 32'(bus.adel_F), 32'd0);
      clearIn();
      bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h0000_3010;
      tick();
      checkVal("exc_eret", bus.PC_F, 32'h0000_4180);
      bus.exc_req = 1'b0;
      tick();
      checkVal("eret_pc", bus.PC_F, 32'h0000_3010);

      // Jump beats a simultaneously taken branch.
      clearIn();
      bus.PC_D = 32'h0000_3010; bus.j_D = 1'b1; bus.index_D = 26'h0000C10;
      bus.br_op_D = 4'd1; bus.imm_D = 16'h0100;
      tick();
      checkVal("j_target", bus.PC_F, 32'h0000_3040);

      // jr targets and fetch-window edges.
      clearIn();
      bus.jr_D = 1'b1; bus.rs_D = 32'h0000_3002;
      #1;
      checkVal("jr_taken", 32'(bus.taken_D), 32'd1);
      tick();
      checkVal("jr_pc", bus.PC_F, 32'h0000_3002);
      checkVal("jr_misalign", 32'(bus.adel_F), 32'd1);
      bus.rs_D = 32'h0000_8000;
      tick();
      checkVal("jr_far_pc", bus.PC_F, 32'h0000_8000);
      checkVal("jr_far_adel", 32'(bus.adel_F), 32'd1);
      bus.rs_D = 32'h0000_6FFC;
      tick();
      checkVal("win_top_in", 32'(bus.adel_F), 32'd0);
      bus.rs_D = 32'h0000_7000;
      tick();
      checkVal("win_top_out", 32'(bus.adel_F), 32'd1);
      bus.rs_D = 32'h0000_2FFC;
      tick();
      checkVal("win_low_out", 32'(bus.adel_F), 32'd1);

      // Taken branch beats jr (rs doubles as jr target and bne operand).
      clearIn();
      bus.PC_D = 32'h0000_3100; bus.br_op_D = 4'd2; bus.rs_D = 32'd1;
      bus.rt_D = 32'd2; bus.jr_D = 1'b1;
      tick();
      checkVal("br_over_jr", bus.PC_F, 32'h0000_3104);

      // Reset while in KILL overrides everything and returns to RUN.
      clearIn();
      bus.br_op_D = 4'd8; bus.rs_D = 32'hFFFF_FFFF;
      tick();
      reset = 1'b1; bus.exc_req = 1'b1; bus.eret_req = 1'b1;
      bus.stall_F = 1'b1; bus.epc = 32'h0000_3010;
      tick();
      checkVal("rst_kill_pc", bus.PC_F, 32'h0000_3000);
      reset = 1'b0;
      clearIn();
      bus.br_op_D = 4'd8; bus.rs_D = 32'hFFFF_FFFF;
      #1;
      checkVal("rst_kill_run", 32'(bus.nullify_F), 32'd1);
      tick();
      checkVal("rst_kill_pc4", bus.PC_F, 32'h0000_3004);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC_F value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180: exception handler entry.
REQ-003 Parameter IMEM_BASE, default 32'h0000_3000, and IMEM_SIZE, default 32'h0000_4000 (bytes): legal fetch window [IMEM_BASE, IMEM_BASE+IMEM_SIZE).
REQ-004 Parameter LIKELY_EN, default 1: 1 enables branch-likely delay-slot nullification.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall_F  in  1  hazard stall; hold PC_F.
REQ-008 PC_D  in  32  PC of instruction in D.
REQ-009 br_op_D  in  4  branch kind in D: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 bgezal, 8 bgezall; 9-15 treated as none.
REQ-010 rs_D, rt_D  in  32 each  forwarded operands.
REQ-011 imm_D  in  16  branch offset.
REQ-012 j_D  in  1  j/jal; index_D  in  26  jump index.
REQ-013 jr_D  in  1  jr/jalr; target is rs_D.
REQ-014 exc_req  in  1  exception taken in M this cycle.
REQ-015 eret_req  in  1  eret committed; epc  in  32  return address.
REQ-016 PC_F  out  32  registered fetch address.
REQ-017 taken_D  out  1  D-stage control transfer taken this cycle.
REQ-018 nullify_F  out  1  kill instruction now in F (delay slot) at next F/D update.
REQ-019 adel_F  out  1  fetch address error for current PC_F.

Function
REQ-020 Condition: beq rs==rt; bne rs!=rt; blez rs<=0, bgtz rs>0, bltz rs<0, bgez/bgezal/bgezall rs>=0, all signed 32-bit.
REQ-021 Branch target = PC_D + 4 + sign_extend({imm_D,2'b00}) mod 2^32; jump target = {PC_D[31:28], index_D, 2'b00}.
REQ-022 Next-PC priority, highest first: reset, exc_req, eret_req, stall_F (hold), j_D, taken branch, jr_D, PC_F+4.
REQ-023 exc_req and eret_req SHALL load PC_F on the next edge regardless of stall_F; exc_req wins if both asserted.
REQ-024 D-stage redirects SHALL take effect one edge after being presented, only when stall_F=0.
REQ-025 taken_D = (j_D | jr_D | branch condition true with br_op_D in 1..8), combinational.
REQ-026 nullify_F = 1 iff LIKELY_EN=1, br_op_D=8, condition false, stall_F=0, exc_req=0, eret_req=0; otherwise 0.
REQ-027 FSM states RUN, KILL: RUN->KILL on edge where nullify_F=1; KILL->RUN unconditionally next edge; in KILL, a br_op_D of the nullified slot SHALL be treated as none (no redirect, taken_D=0).
REQ-028 While FSM=KILL, PC_F SHALL advance by +4 (or exc/eret priority) as in RUN.
REQ-029 adel_F = PC_F[1:0]!=0 or PC_F outside fetch window; registered PC_F SHALL still be presented unchanged.
REQ-030 exc_req and eret_req SHALL force FSM to RUN on the next edge.

Reset
REQ-031 On reset edge: PC_F=RESET_PC, FSM=RUN; thereafter taken_D=0 and nullify_F=0 unless D inputs request otherwise, adel_F reflects RESET_PC.
REQ-032 Reset asserted mid-operation SHALL override exc_req, eret_req, stall_F, and any pending KILL state.

Structure
REQ-033 br_op encodings, FSM state encoding, RESET_PC/HANDLER_PC defaults in shared package pc_pkg.
REQ-034 One sub-module, br_cmp (combinational condition evaluator, REQ-020); remainder flat in pc_unit.

Verification
REQ-035 Reset then 3 unstalled cycles -> PC_F 0x3000, 0x3004, 0x3008, 0x300C.
REQ-036 PC_D=0x3004, br_op_D=1, rs_D=rt_D=5, imm_D=16'hFFFE -> taken_D=1, next PC_F=0x3000; with stall_F=1 same cycle, PC_F held.
REQ-037 br_op_D=8, rs_D=32'hFFFF_FFFF -> nullify_F=1, FSM KILL one cycle, PC_F=PC_F+4; same with rs_D=0 -> taken, nullify_F=0.
REQ-038 stall_F=1, exc_req=1, j_D=1 -> next PC_F=0x4180; exc_req and eret_req together -> 0x4180; eret_req alone, epc=0x3010 -> 0x3010.
REQ-039 jr_D=1, rs_D=0x3002 -> next PC_F=0x3002, adel_F=1; rs_D=0x8000 -> adel_F=1.
REQ-040 In KILL state with br_op_D=1, equal operands -> taken_D=0, PC_F+4; reset asserted in KILL -> PC_F=0x3000, FSM RUN.
